// File: rtl/generation_scheduler_if.sv
// Bus bundle between the generation scheduler and its clients: register-file
// controls, display/engine line channels, engine start/done and BRAM port controls.
// gen_count is only present when GEN_COUNT_EN is defined.
interface generation_scheduler_if #(
  parameter int unsigned ROW_AW = 10
);
  logic              run;
  logic              step;
  logic              frame_end;

  logic              disp_req;
  logic [ROW_AW-1:0] disp_row;
  logic              disp_gnt;
  logic              disp_rvalid;

  logic              eng_rd_req;
  logic [ROW_AW-1:0] eng_rd_row;
  logic              eng_rd_gnt;
  logic              eng_rvalid;

  logic              eng_wr_req;
  logic [ROW_AW-1:0] eng_wr_row;
  logic              eng_wr_gnt;

  logic              eng_start;
  logic              eng_done;

  logic [ROW_AW-1:0] bank0_addr;
  logic              bank0_en;
  logic              bank0_we;
  logic [ROW_AW-1:0] bank1_addr;
  logic              bank1_en;
  logic              bank1_we;

  logic              front_bank;
  logic              busy;
`ifdef GEN_COUNT_EN
  logic [31:0]       gen_count;
`endif

  // Requester side: register file, display, engine and BRAM observers
  modport master (
    output run, step, frame_end,
    output disp_req, disp_row, eng_rd_req, eng_rd_row, eng_wr_req, eng_wr_row, eng_done,
    input  disp_gnt, disp_rvalid, eng_rd_gnt, eng_rvalid, eng_wr_gnt, eng_start,
    input  bank0_addr, bank0_en, bank0_we, bank1_addr, bank1_en, bank1_we,
    input  front_bank, busy
`ifdef GEN_COUNT_EN
    , input gen_count
`endif
  );

  // Scheduler side
  modport slave (
    input  run, step, frame_end,
    input  disp_req, disp_row, eng_rd_req, eng_rd_row, eng_wr_req, eng_wr_row, eng_done,
    output disp_gnt, disp_rvalid, eng_rd_gnt, eng_rvalid, eng_wr_gnt, eng_start,
    output bank0_addr, bank0_en, bank0_we, bank1_addr, bank1_en, bank1_we,
    output front_bank, busy
`ifdef GEN_COUNT_EN
    , output gen_count
`endif
  );
endinterface

// File: rtl/generation_scheduler.sv
// Double-buffered line-bank scheduler: sequences one engine generation at a
// time, arbitrates display/engine access to two line BRAMs and swaps the
// displayed bank at frame end once a generation is complete.
// Optional feature macro: GEN_COUNT_EN adds the 32-bit swap counter gen_count.
module generation_scheduler #(
  parameter int unsigned ROWS   = 720,
  parameter int unsigned ROW_AW = 10
) (
  input logic                   out_stream_aclk,
  input logic                   periph_reset,
  generation_scheduler_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    START     = 2'd1,
    RUN       = 2'd2,
    WAIT_SWAP = 2'd3
  } state_t;

  localparam int unsigned    RW1       = ROW_AW + 1;
  localparam logic [ROW_AW:0] ROW_LIMIT = RW1'(ROWS);

  state_t state;
  state_t state_nxt;
  logic   swap_c;

  logic   front_bank;
  logic   eng_start;
  logic   busy;
  logic   disp_rvalid;
  logic   eng_rvalid;

  logic              in_run_c;
  logic              disp_gnt_c;
  logic              eng_rd_gnt_c;
  logic              eng_wr_gnt_c;
  logic [ROW_AW-1:0] front_addr_c;
  logic              front_en_c;
  logic              back_en_c;

  // Next-state and swap decision; a done coinciding with frame_end swaps straight from RUN
  always_comb begin
    state_nxt = state;
    swap_c    = 1'b0;
    case (state)
      IDLE: begin
        if (bus.run || bus.step) state_nxt = START;
      end
      START: begin
        state_nxt = RUN;
      end
      RUN: begin
        if (bus.eng_done) begin
          if (bus.frame_end) begin
            state_nxt = IDLE;
            swap_c    = 1'b1;
          end else begin
            state_nxt = WAIT_SWAP;
          end
        end
      end
      WAIT_SWAP: begin
        if (bus.frame_end) begin
          state_nxt = IDLE;
          swap_c    = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State, displayed bank and registered status; reset abandons any half-built back bank
  always_ff @(posedge out_stream_aclk or posedge periph_reset) begin
    if (periph_reset) begin
      state      <= IDLE;
      front_bank <= 1'b0;
      eng_start  <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state      <= state_nxt;
      front_bank <= front_bank ^ swap_c;
      eng_start  <= (state_nxt == START);
      busy       <= (state_nxt != IDLE);
    end
  end

  // Grants and front/back bank port values; out-of-range rows are granted but never enable a bank
  always_comb begin
    in_run_c     = (state == RUN);
    disp_gnt_c   = bus.disp_req;
    eng_rd_gnt_c = bus.eng_rd_req & ~bus.disp_req & in_run_c;
    eng_wr_gnt_c = bus.eng_wr_req & in_run_c;
    front_addr_c = disp_gnt_c ? bus.disp_row : bus.eng_rd_row;
    front_en_c   = disp_gnt_c ? ({1'b0, bus.disp_row} < ROW_LIMIT)
                              : (eng_rd_gnt_c & ({1'b0, bus.eng_rd_row} < ROW_LIMIT));
    back_en_c    = eng_wr_gnt_c & ({1'b0, bus.eng_wr_row} < ROW_LIMIT);
  end

  // One-cycle read latency markers; the BRAM latched the pre-swap address on the same edge
  always_ff @(posedge out_stream_aclk or posedge periph_reset) begin
    if (periph_reset) begin
      disp_rvalid <= 1'b0;
      eng_rvalid  <= 1'b0;
    end else begin
      disp_rvalid <= disp_gnt_c;
      eng_rvalid  <= eng_rd_gnt_c;
    end
  end

`ifdef GEN_COUNT_EN
  logic [31:0] gen_count;

  // Completed-generation counter, free-running wrap
  always_ff @(posedge out_stream_aclk or posedge periph_reset) begin
    if (periph_reset) begin
      gen_count <= 32'd0;
    end else if (swap_c) begin
      gen_count <= gen_count + 32'd1;
    end
  end

  assign bus.gen_count = gen_count;
`endif

  assign bus.disp_gnt    = disp_gnt_c;
  assign bus.eng_rd_gnt  = eng_rd_gnt_c;
  assign bus.eng_wr_gnt  = eng_wr_gnt_c;
  assign bus.disp_rvalid = disp_rvalid;
  assign bus.eng_rvalid  = eng_rvalid;
  assign bus.eng_start   = eng_start;
  assign bus.front_bank  = front_bank;
  assign bus.busy        = busy;

  // Front bank is read-only; back bank only ever sees engine writes
  assign bus.bank0_addr = front_bank ? bus.eng_wr_row : front_addr_c;
  assign bus.bank0_en   = front_bank ? back_en_c    : front_en_c;
  assign bus.bank0_we   = front_bank ? back_en_c    : 1'b0;
  assign bus.bank1_addr = front_bank ? front_addr_c : bus.eng_wr_row;
  assign bus.bank1_en   = front_bank ? front_en_c   : back_en_c;
  assign bus.bank1_we   = front_bank ? 1'b0         : back_en_c;

endmodule

// File: tb/tb_generation_scheduler.sv
// Self-checking bench for generation_scheduler: directed scenarios plus a
// randomized sequence of generations checked against a swap-count model.
module tb_generation_scheduler;
  localparam int unsigned ROWS   = 720;
  localparam int unsigned ROW_AW = 10;
  localparam int unsigned RMAX   = (1 << ROW_AW) - 1;

  logic out_stream_aclk;
  logic periph_reset;
  int   errors;
  int   checks;
  int   swaps;

  generation_scheduler_if #(.ROW_AW(ROW_AW)) bus ();

  generation_scheduler #(.ROWS(ROWS), .ROW_AW(ROW_AW)) dut (
    .out_stream_aclk (out_stream_aclk),
    .periph_reset    (periph_reset),
    .bus             (bus)
  );

  initial out_stream_aclk = 1'b0;
  always #5 out_stream_aclk = ~out_stream_aclk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, got=timeout exp=finish");
    $fatal(1);
  end

  task automatic tick();
    @(posedge out_stream_aclk);
    #1;
  endtask

  task automatic drive_quiet();
    bus.run        = 1'b0;
    bus.step       = 1'b0;
    bus.frame_end  = 1'b0;
    bus.eng_done   = 1'b0;
    bus.disp_req   = 1'b0;
    bus.disp_row   = '0;
    bus.eng_rd_req = 1'b0;
    bus.eng_rd_row = '0;
    bus.eng_wr_req = 1'b0;
    bus.eng_wr_row = '0;
  endtask

  task automatic apply_reset();
    drive_quiet();
    periph_reset = 1'b1;
    tick();
    periph_reset = 1'b0;
    swaps = 0;
    tick();
  endtask

  task automatic start_gen();
    bus.step = 1'b1;
    tick();
    bus.step = 1'b0;
    tick();
  endtask

  task automatic finish_gen();
    bus.eng_done = 1'b1;
    tick();
    bus.eng_done  = 1'b0;
    bus.frame_end = 1'b1;
    tick();
    bus.frame_end = 1'b0;
    swaps++;
  endtask

  function automatic logic [ROW_AW-1:0] front_addr();
    return swaps[0] ? bus.bank1_addr : bus.bank0_addr;
  endfunction

  function automatic logic [1:0] front_en_we();
    return swaps[0] ? {bus.bank1_en, bus.bank1_we} : {bus.bank0_en, bus.bank0_we};
  endfunction

  task automatic test_reset();
    drive_quiet();
    periph_reset = 1'b1;
    bus.eng_wr_req = 1'b1;
    bus.eng_rd_req = 1'b1;
    tick();
    checks++;
    if ({bus.front_bank, bus.busy, bus.eng_start, bus.disp_rvalid, bus.eng_rvalid} !== 5'b0) begin
      errors++;
      $display("FAIL reset_state got=%b exp=00000",
               {bus.front_bank, bus.busy, bus.eng_start, bus.disp_rvalid, bus.eng_rvalid});
    end
    checks++;
    if ({bus.eng_wr_gnt, bus.eng_rd_gnt, bus.bank0_we, bus.bank1_we} !== 4'b0) begin
      errors++;
      $display("FAIL reset_no_engine_grant got=%b exp=0000",
               {bus.eng_wr_gnt, bus.eng_rd_gnt, bus.bank0_we, bus.bank1_we});
    end
`ifdef GEN_COUNT_EN
    checks++;
    if (bus.gen_count !== 32'd0) begin
      errors++;
      $display("FAIL reset_gen_count got=%0d exp=0", bus.gen_count);
    end
`endif
    drive_quiet();
    periph_reset = 1'b0;
    swaps = 0;
    tick();
    checks++;
    if ({bus.busy, bus.eng_start} !== 2'b00) begin
      errors++;
      $display("FAIL post_reset_idle got=%b exp=00", {bus.busy, bus.eng_start});
    end
  endtask

  task automatic test_single_run();
    int starts;
    starts = 0;
    bus.run = 1'b1;
    tick();
    starts += int'(bus.eng_start);
    bus.run = 1'b0;
    repeat (10) begin
      tick();
      starts += int'(bus.eng_start);
    end
    bus.eng_done = 1'b1;
    tick();
    starts += int'(bus.eng_start);
    bus.eng_done = 1'b0;
    repeat (4) begin
      tick();
      starts += int'(bus.eng_start);
    end
    bus.frame_end = 1'b1;
    #1;
    checks++;
    if ({bus.front_bank, bus.busy} !== 2'b01) begin
      errors++;
      $display("FAIL run_pre_swap got=%b exp=01", {bus.front_bank, bus.busy});
    end
    tick();
    bus.frame_end = 1'b0;
    swaps++;
    checks++;
    if ({bus.front_bank, bus.busy} !== 2'b10) begin
      errors++;
      $display("FAIL run_swap got=%b exp=10", {bus.front_bank, bus.busy});
    end
    checks++;
    if (starts != 1) begin
      errors++;
      $display("FAIL run_start_pulses got=%0d exp=1", starts);
    end
`ifdef GEN_COUNT_EN
    checks++;
    if (bus.gen_count !== 32'd1) begin
      errors++;
      $display("FAIL run_gen_count got=%0d exp=1", bus.gen_count);
    end
`endif
  endtask

  task automatic test_write_map();
    apply_reset();
    bus.eng_wr_req = 1'b1;
    bus.eng_wr_row = ROW_AW'(37);
    bus.eng_rd_req = 1'b1;
    bus.eng_rd_row = ROW_AW'(5);
    #1;
    checks++;
    if ({bus.eng_wr_gnt, bus.eng_rd_gnt, bus.bank0_we, bus.bank1_we} !== 4'b0) begin
      errors++;
      $display("FAIL idle_no_engine_grant got=%b exp=0000",
               {bus.eng_wr_gnt, bus.eng_rd_gnt, bus.bank0_we, bus.bank1_we});
    end
    bus.step = 1'b1;
    tick();
    bus.step = 1'b0;
    checks++;
    if ({bus.eng_start, bus.eng_wr_gnt, bus.eng_rd_gnt, bus.bank1_we} !== 4'b1000) begin
      errors++;
      $display("FAIL start_no_engine_grant got=%b exp=1000",
               {bus.eng_start, bus.eng_wr_gnt, bus.eng_rd_gnt, bus.bank1_we});
    end
    tick();
    bus.eng_rd_req = 1'b0;
    #1;
    checks++;
    if ({bus.eng_wr_gnt, bus.bank1_en, bus.bank1_we, bus.bank0_we} !== 4'b1110) begin
      errors++;
      $display("FAIL write_back_bank got=%b exp=1110",
               {bus.eng_wr_gnt, bus.bank1_en, bus.bank1_we, bus.bank0_we});
    end
    checks++;
    if (bus.bank1_addr !== ROW_AW'(37)) begin
      errors++;
      $display("FAIL write_addr got=%0d exp=37", bus.bank1_addr);
    end
    bus.eng_wr_row = ROW_AW'(ROWS - 1);
    #1;
    checks++;
    if ({bus.eng_wr_gnt, bus.bank1_en, bus.bank1_we} !== 3'b111) begin
      errors++;
      $display("FAIL write_last_row got=%b exp=111", {bus.eng_wr_gnt, bus.bank1_en, bus.bank1_we});
    end
    bus.eng_wr_row = ROW_AW'(ROWS);
    #1;
    checks++;
    if ({bus.eng_wr_gnt, bus.bank1_en, bus.bank1_we} !== 3'b100) begin
      errors++;
      $display("FAIL write_out_of_range got=%b exp=100", {bus.eng_wr_gnt, bus.bank1_en, bus.bank1_we});
    end
    bus.eng_wr_req = 1'b0;
  endtask

  task automatic test_read_arb();
    bus.disp_req   = 1'b1;
    bus.disp_row   = ROW_AW'(100);
    bus.eng_rd_req = 1'b1;
    bus.eng_rd_row = ROW_AW'(200);
    #1;
    checks++;
    if ({bus.disp_gnt, bus.eng_rd_gnt, front_en_we()} !== 4'b1010) begin
      errors++;
      $display("FAIL read_arb_grants got=%b exp=1010", {bus.disp_gnt, bus.eng_rd_gnt, front_en_we()});
    end
    checks++;
    if (front_addr() !== ROW_AW'(100)) begin
      errors++;
      $display("FAIL read_arb_addr got=%0d exp=100", front_addr());
    end
    tick();
    checks++;
    if ({bus.disp_rvalid, bus.eng_rvalid} !== 2'b10) begin
      errors++;
      $display("FAIL read_arb_rvalid got=%b exp=10", {bus.disp_rvalid, bus.eng_rvalid});
    end
    bus.disp_req = 1'b0;
    #1;
    checks++;
    if ({bus.eng_rd_gnt, front_en_we(), front_addr()} !== {3'b110, ROW_AW'(200)}) begin
      errors++;
      $display("FAIL engine_read got=%b/%0d exp=110/200", {bus.eng_rd_gnt, front_en_we()}, front_addr());
    end
    tick();
    checks++;
    if ({bus.disp_rvalid, bus.eng_rvalid} !== 2'b01) begin
      errors++;
      $display("FAIL engine_rvalid got=%b exp=01", {bus.disp_rvalid, bus.eng_rvalid});
    end
    bus.eng_rd_req = 1'b0;
    bus.disp_req   = 1'b1;
    bus.disp_row   = ROW_AW'(ROWS);
    #1;
    checks++;
    if ({bus.disp_gnt, front_en_we()} !== 3'b100) begin
      errors++;
      $display("FAIL disp_out_of_range got=%b exp=100", {bus.disp_gnt, front_en_we()});
    end
    tick();
    bus.disp_req = 1'b0;
    checks++;
    if ({bus.disp_rvalid, bus.eng_rvalid} !== 2'b10) begin
      errors++;
      $display("FAIL disp_oor_rvalid got=%b exp=10", {bus.disp_rvalid, bus.eng_rvalid});
    end
  endtask

  task automatic test_done_frame_same();
    logic [1:0] old_en_we;
    logic [ROW_AW-1:0] old_addr;
    bus.disp_req  = 1'b1;
    bus.disp_row  = ROW_AW'(3);
    bus.eng_done  = 1'b1;
    bus.frame_end = 1'b1;
    #1;
    old_en_we = front_en_we();
    old_addr  = front_addr();
    checks++;
    if ({old_en_we, old_addr} !== {2'b10, ROW_AW'(3)}) begin
      errors++;
      $display("FAIL swap_edge_read got=%b/%0d exp=10/3", old_en_we, old_addr);
    end
    tick();
    swaps++;
    bus.disp_req  = 1'b0;
    bus.eng_done  = 1'b0;
    bus.frame_end = 1'b0;
    checks++;
    if ({bus.front_bank, bus.busy, bus.disp_rvalid} !== {swaps[0], 2'b01}) begin
      errors++;
      $display("FAIL same_cycle_swap got=%b exp=%b", {bus.front_bank, bus.busy, bus.disp_rvalid},
               {swaps[0], 2'b01});
    end
  endtask

  task automatic test_step();
    int starts;
    bit busy_seen;
    bus.frame_end = 1'b1;
    tick();
    bus.frame_end = 1'b0;
    checks++;
    if ({bus.front_bank, bus.busy} !== {swaps[0], 1'b0}) begin
      errors++;
      $display("FAIL frame_end_idle_ignored got=%b exp=%b", {bus.front_bank, bus.busy}, {swaps[0], 1'b0});
    end
    bus.step = 1'b1;
    tick();
    bus.step = 1'b0;
    bus.frame_end = 1'b1;
    checks++;
    if (bus.eng_start !== 1'b1) begin
      errors++;
      $display("FAIL step_start got=%b exp=1", bus.eng_start);
    end
    tick();
    bus.step = 1'b1;
    tick();
    bus.step = 1'b0;
    bus.frame_end = 1'b0;
    checks++;
    if ({bus.front_bank, bus.busy, bus.eng_start} !== {swaps[0], 2'b10}) begin
      errors++;
      $display("FAIL step_run_ignored got=%b exp=%b", {bus.front_bank, bus.busy, bus.eng_start},
               {swaps[0], 2'b10});
    end
    bus.eng_done = 1'b1;
    tick();
    bus.eng_done = 1'b0;
    bus.step = 1'b1;
    tick();
    bus.step = 1'b0;
    bus.frame_end = 1'b1;
    tick();
    bus.frame_end = 1'b0;
    swaps++;
    checks++;
    if ({bus.front_bank, bus.busy} !== {swaps[0], 1'b0}) begin
      errors++;
      $display("FAIL step_swap got=%b exp=%b", {bus.front_bank, bus.busy}, {swaps[0], 1'b0});
    end
    starts = 0;
    busy_seen = 1'b0;
    repeat (6) begin
      tick();
      starts += int'(bus.eng_start);
      busy_seen |= bus.busy;
    end
    checks++;
    if (starts != 0 || busy_seen) begin
      errors++;
      $display("FAIL step_single_generation got=%0d/%b exp=0/0", starts, busy_seen);
    end
  endtask

  task automatic test_reset_mid();
    if (swaps[0] == 1'b0) begin
      start_gen();
      finish_gen();
    end
    start_gen();
    bus.eng_wr_req = 1'b1;
    bus.eng_wr_row = ROW_AW'(12);
    #1;
    checks++;
    if ({bus.front_bank, bus.eng_wr_gnt, bus.bank0_we} !== 3'b111) begin
      errors++;
      $display("FAIL pre_abort_write got=%b exp=111", {bus.front_bank, bus.eng_wr_gnt, bus.bank0_we});
    end
    bus.eng_done = 1'b1;
    tick();
    bus.eng_done = 1'b0;
    checks++;
    if ({bus.busy, bus.eng_wr_gnt} !== 2'b10) begin
      errors++;
      $display("FAIL wait_swap_no_write got=%b exp=10", {bus.busy, bus.eng_wr_gnt});
    end
    #2;
    periph_reset = 1'b1;
    #1;
    checks++;
    if ({bus.front_bank, bus.busy, bus.eng_start, bus.eng_wr_gnt, bus.bank0_we, bus.bank1_we} !== 6'b0) begin
      errors++;
      $display("FAIL async_abort got=%b exp=000000",
               {bus.front_bank, bus.busy, bus.eng_start, bus.eng_wr_gnt, bus.bank0_we, bus.bank1_we});
    end
    swaps = 0;
    bus.frame_end = 1'b1;
    tick();
    periph_reset = 1'b0;
    tick();
    bus.frame_end = 1'b0;
    bus.eng_wr_req = 1'b0;
    tick();
    checks++;
    if ({bus.front_bank, bus.busy} !== 2'b00) begin
      errors++;
      $display("FAIL abort_no_swap got=%b exp=00", {bus.front_bank, bus.busy});
    end
`ifdef GEN_COUNT_EN
    checks++;
    if (bus.gen_count !== 32'd0) begin
      errors++;
      $display("FAIL abort_gen_count got=%0d exp=0", bus.gen_count);
    end
`endif
  endtask

  task automatic random_cycle(input bit eng_on, input bit exp_start, input bit exp_busy,
                              input bit run_i, input bit step_i, input bit done_i, input bit fe_i);
    int unsigned dr;
    int unsigned rr;
    int unsigned wr;
    bit dq;
    bit rq;
    bit wq;
    bit exp_dg;
    bit exp_rg;
    bit exp_wg;
    bit fr;
    bit f_en;
    bit b_en;
    logic [ROW_AW-1:0] f_addr;
    logic [2*ROW_AW+3:0] exp_banks;
    logic [2*ROW_AW+3:0] got_banks;
    dq = 1'($urandom_range(0, 1));
    rq = 1'($urandom_range(0, 1));
    wq = 1'($urandom_range(0, 1));
    dr = $urandom_range(0, RMAX);
    rr = $urandom_range(0, RMAX);
    wr = $urandom_range(0, RMAX);
    bus.run        = run_i;
    bus.step       = step_i;
    bus.eng_done   = done_i;
    bus.frame_end  = fe_i;
    bus.disp_req   = dq;
    bus.disp_row   = ROW_AW'(dr);
    bus.eng_rd_req = rq;
    bus.eng_rd_row = ROW_AW'(rr);
    bus.eng_wr_req = wq;
    bus.eng_wr_row = ROW_AW'(wr);
    #1;
    fr     = swaps[0];
    exp_dg = dq;
    exp_rg = rq && !dq && eng_on;
    exp_wg = wq && eng_on;
    f_addr = dq ? ROW_AW'(dr) : ROW_AW'(rr);
    f_en   = dq ? (dr < ROWS) : (exp_rg && rr < ROWS);
    b_en   = exp_wg && (wr < ROWS);
    if (!fr) exp_banks = {f_addr, f_en, 1'b0, ROW_AW'(wr), b_en, b_en};
    else     exp_banks = {ROW_AW'(wr), b_en, b_en, f_addr, f_en, 1'b0};
    got_banks = {bus.bank0_addr, bus.bank0_en, bus.bank0_we, bus.bank1_addr, bus.bank1_en, bus.bank1_we};
    checks++;
    if ({bus.disp_gnt, bus.eng_rd_gnt, bus.eng_wr_gnt} !== {exp_dg, exp_rg, exp_wg}) begin
      errors++;
      $display("FAIL rand_grants got=%b exp=%b", {bus.disp_gnt, bus.eng_rd_gnt, bus.eng_wr_gnt},
               {exp_dg, exp_rg, exp_wg});
    end
    checks++;
    if (got_banks !== exp_banks) begin
      errors++;
      $display("FAIL rand_banks got=%h exp=%h", got_banks, exp_banks);
    end
    checks++;
    if ({bus.eng_start, bus.busy, bus.front_bank} !== {exp_start, exp_busy, fr}) begin
      errors++;
      $display("FAIL rand_status got=%b exp=%b", {bus.eng_start, bus.busy, bus.front_bank},
               {exp_start, exp_busy, fr});
    end
    tick();
    checks++;
    if ({bus.disp_rvalid, bus.eng_rvalid} !== {exp_dg, exp_rg}) begin
      errors++;
      $display("FAIL rand_rvalid got=%b exp=%b", {bus.disp_rvalid, bus.eng_rvalid}, {exp_dg, exp_rg});
    end
  endtask

  task automatic test_random();
    for (int g = 0; g < 40; g++) begin
      int unsigned run_len;
      int unsigned sw;
      int unsigned gap;
      bit use_run;
      run_len = $urandom_range(1, 8);
      sw      = $urandom_range(0, 3);
      gap     = $urandom_range(1, 3);
      use_run = 1'($urandom_range(0, 1));
      random_cycle(1'b0, 1'b0, 1'b0, use_run, !use_run, 1'b0, 1'($urandom_range(0, 1)));
      random_cycle(1'b0, 1'b1, 1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0,
                   1'($urandom_range(0, 1)));
      for (int i = 0; i < int'(run_len); i++) begin
        bit last;
        last = (i == int'(run_len) - 1);
        random_cycle(1'b1, 1'b0, 1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), last,
                     last ? (sw == 0) : 1'($urandom_range(0, 1)));
      end
      if (sw != 0) begin
        for (int j = 0; j < int'(sw) - 1; j++) begin
          random_cycle(1'b0, 1'b0, 1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0, 1'b0);
        end
        random_cycle(1'b0, 1'b0, 1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0, 1'b1);
      end
      swaps++;
      for (int k = 0; k < int'(gap); k++) begin
        random_cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      end
    end
`ifdef GEN_COUNT_EN
    checks++;
    if (bus.gen_count !== 32'(swaps)) begin
      errors++;
      $display("FAIL rand_gen_count got=%0d exp=%0d", bus.gen_count, swaps);
    end
`endif
    drive_quiet();
  endtask

  initial begin
    errors = 0;
    checks = 0;
    swaps  = 0;
    periph_reset = 1'b1;
    drive_quiet();
    test_reset();
    test_single_run();
    test_write_map();
    test_read_arb();
    test_done_frame_same();
    test_step();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
